// File: rtl/usbfs_endp_rx_buf_pkg.sv
// Shared USB full-speed definitions for the OUT-endpoint receive path.
// Includes PID codes, the handshake request encoding and the receive FSM states.
package usbfsPkg;

   typedef enum logic [3:0] {
      PID_DATA0 = 4'b0011,
      PID_DATA1 = 4'b1011,
      PID_ACK   = 4'b0010,
      PID_NAK   = 4'b1010,
      PID_STALL = 4'b1110
   } pid_e;

   typedef enum logic [1:0] {
      HS_NONE  = 2'd0,
      HS_ACK   = 2'd1,
      HS_NAK   = 2'd2,
      HS_STALL = 2'd3
   } hs_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } rx_state_e;

endpackage

// File: rtl/usbfs_rx_bank_ram.sv
// Ping-pong payload store: two MAX_PKT-byte banks, one write port and one registered read port.
// The bank select is the address MSB, so a fill and a downstream read never touch the same bank.
module usbfs_rx_bank_ram #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read data holds between strobes, including reads past the stored length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= 8'h00;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/usbfs_endp_rx_buf.sv
// OUT-endpoint receive buffer: CRC/length/toggle checks, ACK/NAK/STALL decision,
// ping-pong payload banks and a valid/ready handoff to the byte-stream stage.
module usbfs_endp_rx_buf
   import usbfsPkg::*;
#(
   parameter int MAX_PKT = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_sop,
   input  logic                     i_dataPid,
   input  logic                     i_byteValid,
   input  logic [7:0]               i_byte,
   input  logic                     i_eop,
   input  logic                     i_crcOk,
   input  logic                     i_toggleClr,
   output logic                     o_hsAck,
   output logic                     o_hsNak,
   output logic                     o_hsStall,
   input  logic                     i_erStall,
   output logic                     o_erValid,
   input  logic                     i_erReady,
   input  logic                     i_erRdEn,
   input  logic [$clog2(MAX_PKT)-1:0] i_erRdIdx,
   output logic [7:0]               o_erRdByte,
   output logic [$clog2(MAX_PKT):0] o_erRdNBytes
);

   localparam int AW = $clog2(MAX_PKT);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] PKT_LEN = CW'(MAX_PKT);
   localparam logic [CW-1:0] CNT_OVF = CW'(MAX_PKT + 1);

   // One count past MAX_PKT marks overflow and sticks there.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == CNT_OVF) ? c : c + 1'b1;
   endfunction

   rx_state_e     state_q, state_d;
   hs_e           hs_q, hs_d;
   logic          drop_stall_q, drop_stall_d;
   logic          exp_tog_q;
   logic          pid_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] n_bytes_q;
   logic [CW-1:0] rd_n_bytes_q;
   logic          er_valid_q;
   logic          wr_bank_q, rd_bank_q;
   logic          accept, start;

   wire handoff  = er_valid_q && i_erReady;
   wire overflow = (cnt_q == CNT_OVF);
   wire byte_stb = (state_q == ST_RECV) && !i_sop && i_byteValid;
   wire wr_en    = byte_stb && (cnt_q < PKT_LEN);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         hs_q         <= HS_NONE;
         drop_stall_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hs_q         <= hs_d;
         drop_stall_q <= drop_stall_d;
      end
   end

   // A new SOP always wins: in RECV/DROP it silently aborts the packet and re-evaluates.
   always_comb begin
      state_d      = state_q;
      hs_d         = HS_NONE;
      drop_stall_d = drop_stall_q;
      accept       = 1'b0;
      start        = 1'b0;
      case (state_q)
         ST_RECV: begin
            if (i_eop && !i_sop) begin
               state_d = ST_IDLE;
               if (i_crcOk && !overflow) begin
                  hs_d   = HS_ACK;
                  accept = (pid_q == exp_tog_q);
               end
            end
         end
         ST_DROP: begin
            if (i_eop && !i_sop) begin
               state_d = ST_IDLE;
               if (i_crcOk) hs_d = drop_stall_q ? HS_STALL : HS_NAK;
            end
         end
         default: ;
      endcase
      if (i_sop) begin
         if (i_erStall) begin
            state_d      = ST_DROP;
            drop_stall_d = 1'b1;
         end else if (er_valid_q && !handoff) begin
            state_d      = ST_DROP;
            drop_stall_d = 1'b0;
         end else begin
            state_d = ST_RECV;
            start   = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         exp_tog_q    <= 1'b0;
         pid_q        <= 1'b0;
         cnt_q        <= '0;
         n_bytes_q    <= '0;
         rd_n_bytes_q <= '0;
         er_valid_q   <= 1'b0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b1;
      end else begin
         if (i_toggleClr)  exp_tog_q <= 1'b0;
         else if (accept)  exp_tog_q <= ~exp_tog_q;
         if (start) begin
            cnt_q <= '0;
            pid_q <= i_dataPid;
         end else if (byte_stb) begin
            cnt_q <= sat_inc(cnt_q);
         end
         if (handoff) begin
            rd_bank_q    <= wr_bank_q;
            wr_bank_q    <= ~wr_bank_q;
            rd_n_bytes_q <= n_bytes_q;
            er_valid_q   <= 1'b0;
         end
         if (accept) begin
            er_valid_q <= 1'b1;
            n_bytes_q  <= cnt_q;
         end
      end
   end

   usbfs_rx_bank_ram #(
      .DEPTH  (2 * MAX_PKT),
      .ADDR_W (AW + 1)
   ) u_ram (
      .clk   (i_clk),
      .rst   (i_rst),
      .we    (wr_en),
      .waddr ({wr_bank_q, cnt_q[AW-1:0]}),
      .wdata (i_byte),
      .re    (i_erRdEn),
      .raddr ({rd_bank_q, i_erRdIdx}),
      .rdata (o_erRdByte)
   );

   assign o_hsAck      = (hs_q == HS_ACK);
   assign o_hsNak      = (hs_q == HS_NAK);
   assign o_hsStall    = (hs_q == HS_STALL);
   assign o_erValid    = er_valid_q;
   assign o_erRdNBytes = rd_n_bytes_q;

endmodule

// File: tb/tb_usbfs_endp_rx_buf.sv
// Scoreboard bench for usbfs_endp_rx_buf: directed packets then randomized traffic,
// checked against a packet-level model of the endpoint.
module tb_usbfs_endp_rx_buf;

   localparam int MAX_PKT = 8;
   localparam int AW      = $clog2(MAX_PKT);

   logic          clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_sop = 1'b0, i_dataPid = 1'b0, i_byteValid = 1'b0;
   logic [7:0]    i_byte = 8'h00;
   logic          i_eop = 1'b0, i_crcOk = 1'b0, i_toggleClr = 1'b0;
   logic          o_hsAck, o_hsNak, o_hsStall;
   logic          i_erStall = 1'b0, i_erReady = 1'b0, i_erRdEn = 1'b0;
   logic [AW-1:0] i_erRdIdx = '0;
   logic          o_erValid;
   logic [7:0]    o_erRdByte;
   logic [AW:0]   o_erRdNBytes;

   always #5 clk = ~clk;

   usbfs_endp_rx_buf #(.MAX_PKT(MAX_PKT)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_sop(i_sop), .i_dataPid(i_dataPid),
      .i_byteValid(i_byteValid), .i_byte(i_byte), .i_eop(i_eop), .i_crcOk(i_crcOk),
      .i_toggleClr(i_toggleClr), .o_hsAck(o_hsAck), .o_hsNak(o_hsNak), .o_hsStall(o_hsStall),
      .i_erStall(i_erStall), .o_erValid(o_erValid), .i_erReady(i_erReady),
      .i_erRdEn(i_erRdEn), .i_erRdIdx(i_erRdIdx), .o_erRdByte(o_erRdByte),
      .o_erRdNBytes(o_erRdNBytes)
   );

   int total = 0;
   int bad   = 0;

   // Expected {ack, nak, stall, erValid} after each EOP; read bytes; handoff byte counts.
   logic [3:0]  qh[$];
   logic [7:0]  qr[$];
   logic [AW:0] qn[$];

   // Endpoint model: expected toggle, pending fill packet, and the handed-off packet.
   bit         m_tog;
   bit         m_pend;
   logic [7:0] m_fill[MAX_PKT];
   int         m_fill_n;
   logic [7:0] m_rd[MAX_PKT];
   int         m_rd_n;

   localparam logic [3:0] E_ACK = 4'b1000, E_NAK = 4'b0100, E_STALL = 4'b0010;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: capture what the DUT saw at the edge, compare on the following falling edge.
   logic eop_cap = 1'b0, rd_cap = 1'b0, hand_cap = 1'b0;
   always @(posedge clk) begin
      eop_cap  <= i_eop;
      rd_cap   <= i_erRdEn;
      hand_cap <= o_erValid && i_erReady;
   end

   always @(negedge clk) begin
      if (eop_cap) begin
         if (qh.size() == 0) check("hs_unexpected_eop", 1, 0);
         else check("handshake", {o_hsAck, o_hsNak, o_hsStall, o_erValid}, qh.pop_front());
      end else if (o_hsAck || o_hsNak || o_hsStall) begin
         check("hs_stray", {o_hsAck, o_hsNak, o_hsStall}, 3'b000);
      end
      if (rd_cap) begin
         if (qr.size() == 0) check("rd_unexpected", 1, 0);
         else check("rd_byte", o_erRdByte, qr.pop_front());
      end
      if (hand_cap) begin
         if (qn.size() == 0) check("handoff_unexpected", 1, 0);
         else check("rd_nbytes", o_erRdNBytes, qn.pop_front());
      end
   end

   task automatic model_handoff();
      if (m_pend) begin
         for (int i = 0; i < MAX_PKT; i++) m_rd[i] = m_fill[i];
         m_rd_n = m_fill_n;
         m_pend = 1'b0;
         qn.push_back((AW+1)'(m_fill_n));
      end
   endtask

   task automatic do_handoff();
      model_handoff();
      i_erReady = 1'b1;
      tick();
      i_erReady = 1'b0;
   endtask

   task automatic rd(input int idx);
      i_erRdEn  = 1'b1;
      i_erRdIdx = AW'(idx);
      qr.push_back(m_rd[idx]);
      tick();
      i_erRdEn = 1'b0;
   endtask

   task automatic read_all();
      for (int i = 0; i < m_rd_n; i++) rd(i);
   endtask

   task automatic clr_toggle();
      i_toggleClr = 1'b1;
      m_tog = 1'b0;
      tick();
      i_toggleClr = 1'b0;
   endtask

   // cls: 1 = stalled, 2 = busy (NAK), 3 = receive and judge CRC/length/toggle.
   task automatic send_pkt(input bit pid, input int len, input logic [7:0] base,
                           input logic [7:0] step, input bit crc, input bit stall,
                           input bit rdy, input bit clr, input bit lost);
      int         cls;
      logic [7:0] data[16];
      logic [3:0] e;
      if (rdy) model_handoff();
      if (stall)       cls = 1;
      else if (m_pend) cls = 2;
      else             cls = 3;
      i_sop = 1'b1; i_dataPid = pid; i_erStall = stall; i_erReady = rdy;
      tick();
      i_sop = 1'b0; i_erStall = 1'b0; i_erReady = 1'b0;
      for (int i = 0; i < len; i++) begin
         data[i]     = 8'(base + i * step);
         i_byteValid = 1'b1;
         i_byte      = data[i];
         tick();
         i_byteValid = 1'b0;
         if ($urandom_range(0, 3) == 0) tick();
      end
      if (lost) return;
      e = 4'b0000;
      if (cls == 1 && crc) e = E_STALL;
      if (cls == 2 && crc) e = E_NAK;
      if (cls == 3 && crc && len <= MAX_PKT) begin
         e = E_ACK;
         if (pid == m_tog) begin
            for (int i = 0; i < len; i++) m_fill[i] = data[i];
            m_fill_n = len;
            m_pend   = 1'b1;
            m_tog    = ~m_tog;
         end
      end
      if (clr) m_tog = 1'b0;
      e[0] = m_pend;
      qh.push_back(e);
      i_eop = 1'b1; i_crcOk = crc; i_toggleClr = clr;
      tick();
      i_eop = 1'b0; i_crcOk = 1'b0; i_toggleClr = 1'b0;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"},    o_hsAck,      0);
      check({tag, "_nak"},    o_hsNak,      0);
      check({tag, "_stall"},  o_hsStall,    0);
      check({tag, "_valid"},  o_erValid,    0);
      check({tag, "_nbytes"}, o_erRdNBytes, 0);
      check({tag, "_rdbyte"}, o_erRdByte,   0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      m_tog = 1'b0; m_pend = 1'b0; m_fill_n = 0; m_rd_n = 0;
      #3;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      tick();

      // DATA0 11 22 33 accepted, then a NAKed repeat that must not disturb it.
      send_pkt(1'b0, 3, 8'h11, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_pkt(1'b0, 3, 8'h55, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_handoff();
      read_all();
      tick();
      check("rd_hold", o_erRdByte, m_rd[m_rd_n - 1]);
      // Duplicate DATA0, oversize DATA1, bad-CRC DATA1.
      send_pkt(1'b0, 3, 8'hA0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_pkt(1'b1, 9, 8'h30, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_pkt(1'b1, 3, 8'h40, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Stall, then zero-length DATA1.
      send_pkt(1'b1, 2, 8'h60, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      send_pkt(1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_handoff();
      // DATA0 accepted, toggle cleared, DATA0 accepted again via SOP-coincident handoff.
      send_pkt(1'b0, 8, 8'h70, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      clr_toggle();
      send_pkt(1'b0, 5, 8'h81, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      read_all();
      do_handoff();
      read_all();
      // Clear coincident with an accepting flip leaves DATA0 expected.
      send_pkt(1'b1, 2, 8'h90, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      do_handoff();
      send_pkt(1'b0, 1, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_handoff();
      read_all();
      // Lost EOP followed by a fresh packet.
      send_pkt(1'b1, 2, 8'hD0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_pkt(1'b1, 4, 8'hE0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_handoff();
      read_all();

      // Async reset after 4 bytes of a DATA0 packet.
      i_sop = 1'b1; i_dataPid = 1'b0;
      tick();
      i_sop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         i_byteValid = 1'b1; i_byte = 8'(8'hF0 + i);
         tick();
      end
      i_byteValid = 1'b0;
      #2 i_rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      m_tog = 1'b0; m_pend = 1'b0; m_rd_n = 0;
      tick();
      tick();
      i_rst = 1'b0;
      tick();
      send_pkt(1'b0, 3, 8'h21, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_handoff();
      read_all();

      // Randomized traffic.
      for (int n = 0; n < 200; n++) begin
         int r;
         bit pid;
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            do_handoff();
            read_all();
         end else if (r == 2) begin
            clr_toggle();
         end
         pid = ($urandom_range(0, 3) == 0) ? ~m_tog : m_tog;
         send_pkt(pid, int'($urandom_range(0, 10)), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0);
      end
      do_handoff();
      read_all();
      tick();
      tick();
      check("qh_left", qh.size(), 0);
      check("qr_left", qr.size(), 0);
      check("qn_left", qn.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usbfs_endp_rx_buf.md
# usbfs_endp_rx_buf

OUT-endpoint packet buffer sitting directly upstream of the endpoint byte-stream stage. It takes DATA0/DATA1 payload bytes from the USB full-speed packet receiver and checks CRC, length and data toggle. It decides the ACK/NAK/STALL handshake, stores accepted payloads in a ping-pong pair of MAX_PKT-byte banks, and hands complete packets downstream through a valid/ready handshake plus a random-access read port.

## Interface
- MAX_PKT, 8: maximum payload bytes per packet; power of two, 8..64.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_sop  in  1  pulse: start of DATA packet addressed to this OUT endpoint.
- i_dataPid  in  1  with i_sop: 0=DATA0, 1=DATA1.
- i_byteValid  in  1  payload byte strobe.
- i_byte  in  8  payload byte.
- i_eop  in  1  pulse: end of packet; CRC bytes already stripped.
- i_crcOk  in  1  with i_eop: CRC16 good.
- i_toggleClr  in  1  pulse: expected toggle := DATA0 (SETUP / SetConfiguration).
- o_hsAck, o_hsNak, o_hsStall  out  1 each  one-hot handshake request pulses.
- i_erStall  in  1  downstream halt request.
- o_erValid  out  1  a complete packet is waiting in the fill bank.
- i_erReady  in  1  downstream can take a packet.
- i_erRdEn  in  1  read strobe on the handed-off bank.
- i_erRdIdx  in  $clog2(MAX_PKT)  byte index.
- o_erRdByte  out  8  read data.
- o_erRdNBytes  out  $clog2(MAX_PKT)+1  byte count of the handed-off bank.

## Operation
- Reset: state IDLE, expected toggle DATA0, o_erValid=0, o_erRdNBytes=0, o_erRdByte=0, all handshake pulses 0, wrBank=0, rdBank=1.
- FSM states: IDLE, RECV, DROP.
- IDLE + i_sop:
  - i_erStall=1 -> DROP (stall).
  - else, packet still pending after this cycle's handoff -> DROP (nak).
  - else -> RECV; clear count, latch i_dataPid.
- RECV + i_byteValid:
  - count<MAX_PKT -> write byte to wrBank[count].
  - count increments, saturating at MAX_PKT+1 (overflow flag).
- RECV + i_eop, exactly one outcome:
  - !i_crcOk or overflow -> no handshake, discard.
  - pid!=expected toggle -> duplicate: ACK, discard, toggle unchanged.
  - else -> ACK, toggle flips, nBytes latched, o_erValid set.
  - All outcomes return to IDLE.
- DROP: bytes ignored. On i_eop: CRC bad -> no handshake; else STALL or NAK per the reason latched at entry. Return to IDLE.
- i_sop in RECV/DROP (lost EOP): abort the current packet silently, then re-evaluate as from IDLE in the same cycle.
- Handoff when o_erValid && i_erReady:
  - rdBank<=wrBank, wrBank<=~wrBank.
  - o_erRdNBytes<=nBytes.
  - o_erValid<=0.
  - The read bank holds its data until the next handoff.
- Zero-length packet: ACKed, o_erValid with nBytes=0.
- i_toggleClr coincident with a toggle flip: clear wins, expected toggle=DATA0.
- i_erRdIdx>=o_erRdNBytes: o_erRdByte holds stale bank contents; no error is flagged.

## Timing
- Handshake pulse is exactly 1 cycle, in the cycle after i_eop.
- o_erValid rises in the cycle after i_eop, together with o_hsAck.
- o_erRdByte is registered: valid the cycle after i_erRdEn. It holds its value when i_erRdEn=0.
- i_sop in the same cycle as a handoff sees the freed bank and goes to RECV, not NAK.
- Downstream reading the read bank while the fill bank receives never conflicts: the two banks are distinct.
- Async reset mid-packet: the packet is lost and no handshake is emitted. The toggle returns to DATA0.

## Structure
- Shared package usbfsPkg:
  - PID codes (DATA0/DATA1/ACK/NAK/STALL).
  - Handshake encoding.
  - FSM state typedef.
- One sub-module, usbfs_rx_bank_ram:
  - 2*MAX_PKT x 8 simple dual-port memory.
  - Write port addressed {wrBank,count}.
  - Registered read port addressed {rdBank,i_erRdIdx}.
- FSM, counters, toggle and handshake logic live in the top.

## Test plan
- Reset, then DATA0, 3 bytes 11 22 33, good CRC -> o_hsAck 1 cycle after eop; o_erValid=1. After handoff, o_erRdNBytes=3 and idx 0..2 read 11 22 33 with 1-cycle latency. Expected toggle becomes DATA1.
- Repeat DATA0 before the handoff -> NAK, o_erValid stays 1, the original contents are unchanged. Repeat after the handoff -> ACK but discarded (duplicate), o_erValid stays 0.
- DATA1 with 9 bytes at MAX_PKT=8, or any packet with i_crcOk=0 -> no handshake pulse, no o_erValid, toggle unchanged.
- i_erStall=1 then DATA1 packet -> o_hsStall only, nothing stored.
- Zero-length DATA1 -> ACK, o_erValid with nBytes 0. i_toggleClr then DATA0 -> accepted.
- Assert i_rst mid-RECV after 4 bytes -> all outputs at reset values, no handshake. The next DATA0 packet is accepted normally.
